arc4_gen: RTL and testbench

- Parametrised, self-contained ARC4 decrypt engine with internal 256x8 S-box state.
- Generalises the lab ARC4 datapath: configurable key length and message address width, plus an optional keystream-drop mode.
- Runs init, KSA and PRGA under one FSM.
- Reads a length-prefixed ciphertext from an external synchronous ROM and writes the length-prefixed plaintext to an external RAM.
- Sits between the key source (switches or cracker) and the ct/pt memories.

---
 rtl/arc4_gen.sv | 262 ++++++++++++++++++++++++++
 tb/tb_arc4_gen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_gen.sv
// arc4_gen: ARC4 decrypt engine with an internal 256x8 S-box.
// Runs init, KSA and PRGA over a length-prefixed ct ROM and writes pt RAM.
// Ports: clk, rst (sync, active-high), en/rdy start handshake,
//   done (1-cycle pulse), key (byte 0 in the MSBs, latched at start),
//   ct_addr/ct_rddata (sync ROM, 1-cycle latency),
//   pt_addr/pt_wrdata/pt_wren (RAM write port).
// Option: define ARC4_DROP_EN to discard DROP_BYTES keystream bytes
//   after KSA; undefined builds plain ARC4.
module arc4_gen #(
  parameter int KEY_BYTES  = 3,
  parameter int ADDR_W     = 8,
  parameter int DROP_BYTES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  output logic                   done,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [ADDR_W-1:0]      pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  localparam int KW = 8 * KEY_BYTES;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_KSA_RI = 4'd2;
  localparam logic [3:0] S_KSA_J  = 4'd3;
  localparam logic [3:0] S_KSA_WI = 4'd4;
  localparam logic [3:0] S_KSA_WJ = 4'd5;
  localparam logic [3:0] S_LEN    = 4'd6;
  localparam logic [3:0] S_P_RI   = 4'd7;
  localparam logic [3:0] S_P_J    = 4'd8;
  localparam logic [3:0] S_P_WI   = 4'd9;
  localparam logic [3:0] S_P_WJ   = 4'd10;
  localparam logic [3:0] S_P_RK   = 4'd11;
  localparam logic [3:0] S_P_OUT  = 4'd12;
  localparam logic [3:0] S_DONE   = 4'd13;

  logic [3:0]        r_state;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [7:0]        r_k;
  logic [7:0]        r_len;
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [KW-1:0]     r_key;
  logic [ADDR_W-1:0] r_ct_addr;
  logic [ADDR_W-1:0] r_pt_addr;
  logic [7:0]        r_pt_wrdata;
  logic              r_pt_wren;
  logic [7:0]        r_rdata;
  logic [7:0]        r_s [256];
`ifdef ARC4_DROP_EN
  logic              r_drop;
  logic [15:0]       r_dcnt;
`endif

  logic [7:0]    w_kbyte;
  logic [KW-1:0] w_krot;
  logic [7:0]    w_i1;
  logic [7:0]    w_k1;
  logic [7:0]    w_jk;
  logic [7:0]    w_jp;
  logic [7:0]    w_pidx;
  logic [7:0]    w_addr;
  logic [7:0]    w_wdata;
  logic          w_we;

  // The key register rotates one byte per KSA step, so its top
  // byte is always key_byte[i mod KEY_BYTES] without a divider.
  assign w_kbyte = r_key[KW-1 -: 8];

  generate
    if (KEY_BYTES == 1) begin : g_rot1
      assign w_krot = r_key;
    end else begin : g_rotn
      assign w_krot = {r_key[KW-9:0], r_key[KW-1 -: 8]};
    end
  endgenerate

  assign w_i1   = r_i + 8'd1;
  assign w_k1   = r_k + 8'd1;
  assign w_jk   = r_j + r_rdata + w_kbyte;
  assign w_jp   = r_j + r_rdata;
  assign w_pidx = r_si + r_sj;

  assign rdy       = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);
  assign ct_addr   = r_ct_addr;
  assign pt_addr   = r_pt_addr;
  assign pt_wrdata = r_pt_wrdata;
  assign pt_wren   = r_pt_wren;

  // Single S-box port: one read or write per cycle.
  // Swaps write S[i] with the value read from S[j], then S[j]
  // with the value read from S[i]; when i==j both writes carry
  // the original S[i], so the entry is unchanged.
  always_comb begin
    w_addr  = r_i;
    w_wdata = r_i;
    w_we    = 1'b0;
    unique case (r_state)
      S_INIT: begin
        w_we = 1'b1;
      end
      S_KSA_J:  w_addr = w_jk;
      S_KSA_WI: begin
        w_we    = 1'b1;
        w_wdata = r_rdata;
      end
      S_KSA_WJ: begin
        w_addr  = r_j;
        w_we    = 1'b1;
        w_wdata = r_si;
      end
      S_P_RI: w_addr = w_i1;
      S_P_J:  w_addr = w_jp;
      S_P_WI: begin
        w_we    = 1'b1;
        w_wdata = r_rdata;
      end
      S_P_WJ: begin
        w_addr  = r_j;
        w_we    = 1'b1;
        w_wdata = r_si;
      end
      S_P_RK: w_addr = w_pidx;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_s[w_addr] <= w_wdata;
    r_rdata <= r_s[w_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_len       <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_key       <= '0;
      r_ct_addr   <= '0;
      r_pt_addr   <= '0;
      r_pt_wrdata <= '0;
      r_pt_wren   <= 1'b0;
`ifdef ARC4_DROP_EN
      r_drop      <= 1'b0;
      r_dcnt      <= '0;
`endif
    end else begin
      r_pt_wren <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (en) begin
            r_key     <= key;
            r_i       <= '0;
            r_j       <= '0;
            r_ct_addr <= '0;
            r_state   <= S_INIT;
          end
        end
        S_INIT: begin
          r_i <= w_i1;
          if (r_i == 8'hFF) r_state <= S_KSA_RI;
        end
        S_KSA_RI: r_state <= S_KSA_J;
        S_KSA_J: begin
          r_si    <= r_rdata;
          r_j     <= w_jk;
          r_state <= S_KSA_WI;
        end
        S_KSA_WI: r_state <= S_KSA_WJ;
        S_KSA_WJ: begin
          r_key <= w_krot;
          r_i   <= w_i1;
          if (r_i == 8'hFF) begin
            r_j <= '0;
`ifdef ARC4_DROP_EN
            if (DROP_BYTES > 0) begin
              r_drop  <= 1'b1;
              r_dcnt  <= '0;
              r_state <= S_P_RI;
            end else begin
              r_state <= S_LEN;
            end
`else
            r_state <= S_LEN;
`endif
          end else begin
            r_state <= S_KSA_RI;
          end
        end
        S_LEN: begin
          r_len       <= ct_rddata;
          r_k         <= 8'd1;
          r_pt_addr   <= '0;
          r_pt_wrdata <= ct_rddata;
          r_pt_wren   <= 1'b1;
          if (ct_rddata == 8'd0) begin
            r_state <= S_DONE;
          end else begin
            r_ct_addr <= ADDR_W'(8'd1);
            r_state   <= S_P_RI;
          end
        end
        S_P_RI: begin
          r_i     <= w_i1;
          r_state <= S_P_J;
        end
        S_P_J: begin
          r_si    <= r_rdata;
          r_j     <= w_jp;
          r_state <= S_P_WI;
        end
        S_P_WI: begin
          r_sj    <= r_rdata;
          r_state <= S_P_WJ;
        end
        S_P_WJ: r_state <= S_P_RK;
        S_P_RK: r_state <= S_P_OUT;
        S_P_OUT: begin
`ifdef ARC4_DROP_EN
          if (r_drop) begin
            r_dcnt <= r_dcnt + 16'd1;
            if (r_dcnt == 16'(DROP_BYTES - 1)) begin
              r_drop  <= 1'b0;
              r_state <= S_LEN;
            end else begin
              r_state <= S_P_RI;
            end
          end else
`endif
          begin
            r_pt_wren   <= 1'b1;
            r_pt_addr   <= ADDR_W'(r_k);
            r_pt_wrdata <= ct_rddata ^ r_rdata;
            if (r_k == r_len) begin
              r_state <= S_DONE;
            end else begin
              r_k       <= w_k1;
              r_ct_addr <= ADDR_W'(w_k1);
              r_state   <= S_P_RI;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_gen.sv
// tb_arc4_gen: directed + random checks of arc4_gen against an
// RC4 reference model (3-byte and 4-byte key instances).
module tb_arc4_gen;

`ifdef ARC4_DROP_EN
  localparam int DROP = 256;
`else
  localparam int DROP = 0;
`endif
  localparam int LIM = 256 + 1536 + 8 * 256 + 8 * DROP + 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        en_a, rdy_a, done_a, wren_a;
  logic [23:0] key_a;
  logic [7:0]  cta_addr, cta_rd, pta_addr, pta_wd;

  logic        en_b, rdy_b, done_b, wren_b;
  logic [31:0] key_b;
  logic [9:0]  ctb_addr, ptb_addr;
  logic [7:0]  ctb_rd, ptb_wd;

  arc4_gen #(.KEY_BYTES(3), .ADDR_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a),
    .done(done_a), .key(key_a),
    .ct_addr(cta_addr), .ct_rddata(cta_rd),
    .pt_addr(pta_addr), .pt_wrdata(pta_wd),
    .pt_wren(wren_a)
  );

  arc4_gen #(.KEY_BYTES(4), .ADDR_W(10)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b),
    .done(done_b), .key(key_b),
    .ct_addr(ctb_addr), .ct_rddata(ctb_rd),
    .pt_addr(ptb_addr), .pt_wrdata(ptb_wd),
    .pt_wren(wren_b)
  );

  logic [7:0] ct_a [256];
  logic [7:0] pt_a [256];
  logic [7:0] ct_b [1024];
  logic [7:0] pt_b [1024];

  logic clr_a, clr_b;
  int wcnt_a, nexp_a, oerr_a, dcnt_a, ctmax_a;
  int wcnt_b, nexp_b, oerr_b, dcnt_b;

  int total = 0;
  int bad = 0;
  int ks [256];

  logic [7:0] PT_KEY [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E,
                             8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] CT_KEY [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9,
                             8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] PT_WIK [5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
  logic [7:0] CT_WIK [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};

  always @(posedge clk) begin
    if (clr_a) begin
      wcnt_a = 0; nexp_a = 0; oerr_a = 0;
      dcnt_a = 0; ctmax_a = 0;
      for (int n = 0; n < 256; n++) pt_a[n] = 8'hEE;
    end else begin
      if (wren_a) begin
        if (int'(pta_addr) != nexp_a) oerr_a++;
        nexp_a++;
        wcnt_a++;
        pt_a[pta_addr] = pta_wd;
      end
      if (done_a) dcnt_a++;
      if (!rdy_a && int'(cta_addr) > ctmax_a)
        ctmax_a = int'(cta_addr);
    end
    cta_rd <= ct_a[cta_addr];
  end

  always @(posedge clk) begin
    if (clr_b) begin
      wcnt_b = 0; nexp_b = 0; oerr_b = 0; dcnt_b = 0;
      for (int n = 0; n < 256; n++) pt_b[n] = 8'hEE;
    end else begin
      if (wren_b) begin
        if (int'(ptb_addr) != nexp_b) oerr_b++;
        nexp_b++;
        wcnt_b++;
        pt_b[ptb_addr] = ptb_wd;
      end
      if (done_b) dcnt_b++;
    end
    ctb_rd <= ct_b[ctb_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Plain RC4 (optionally dropping DROP bytes) -> ks[0..n-1].
  task automatic model(input logic [127:0] k, input int kb,
                       input int n);
    int s [256];
    int i, j, t;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + int'(k[8*(kb-1-(x%kb)) +: 8])) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int c = 0; c < DROP + n; c++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (c >= DROP) ks[c-DROP] = s[(s[i] + s[j]) % 256];
    end
  endtask

  task automatic wait_done_a(output int lat, output bit seen);
    lat = 1; seen = 0;
    while (lat < LIM && !seen) begin
      if (done_a) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  // Called in the idle cycle after done.
  task automatic check_a(input string tag, input logic [23:0] k,
                         input int len);
    chk({tag, "_rdy"}, 32'(rdy_a), 1);
    chk({tag, "_ndone"}, 32'(dcnt_a), 1);
    chk({tag, "_nwr"}, 32'(wcnt_a), 32'(len + 1));
    chk({tag, "_order"}, 32'(oerr_a), 0);
    chk({tag, "_ctmax"}, 32'(ctmax_a <= len), 1);
    chk({tag, "_pt0"}, 32'(pt_a[0]), 32'(len));
    model({104'd0, k}, 3, len);
    for (int n = 1; n <= len; n++)
      chk($sformatf("%s_pt%0d", tag, n), 32'(pt_a[n]),
          32'(ct_a[n] ^ ks[n-1][7:0]));
  endtask

  task automatic run_a(input logic [23:0] k, input int len,
                       input bit hold, input string tag);
    int lat;
    bit seen;
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    key_a = k;
    en_a = 1'b1;
    @(negedge clk);
    if (!hold) en_a = 1'b0;
    wait_done_a(lat, seen);
    en_a = 1'b0;
    chk({tag, "_seen"}, 32'(seen), 1);
    chk({tag, "_lat"},
        32'(lat <= 256 + 1536 + 8 * (len + 1) + 8 + 8 * DROP), 1);
    @(negedge clk);
    check_a(tag, k, len);
  endtask

  task automatic load_key_ct();
    ct_a[0] = 8'd9;
    for (int n = 0; n < 9; n++) ct_a[n+1] = CT_KEY[n];
  endtask

  task automatic lit_key(input string tag);
`ifndef ARC4_DROP_EN
    for (int n = 0; n < 9; n++)
      chk($sformatf("%s_lit%0d", tag, n), 32'(pt_a[n+1]),
          32'(PT_KEY[n]));
`else
    chk({tag, "_lit0"}, 32'(pt_a[0]), 9);
`endif
  endtask

  initial begin
    int lat, len;
    bit seen;
    logic [23:0] rk;

    rst = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    key_a = '0; key_b = '0;
    clr_a = 1'b1; clr_b = 1'b1;
    for (int n = 0; n < 256; n++) ct_a[n] = 8'd0;
    for (int n = 0; n < 1024; n++) ct_b[n] = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy_a), 1);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_wren", 32'(wren_a), 0);
    chk("rst_ctaddr", 32'(cta_addr), 0);
    chk("rst_ptaddr", 32'(pta_addr), 0);
    chk("rst_ptdata", 32'(pta_wd), 0);
    chk("rst_rdy_b", 32'(rdy_b), 1);
    rst = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    @(negedge clk);

    // Key / Plaintext
    load_key_ct();
    run_a(24'h4B6579, 9, 1'b0, "key");
    lit_key("key");

    // Wiki / pedia on the 4-byte key instance
    ct_b[0] = 8'd5;
    for (int n = 0; n < 5; n++) ct_b[n+1] = CT_WIK[n];
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    key_b = 32'h57696B69;
    en_b = 1'b1;
    @(negedge clk);
    en_b = 1'b0;
    lat = 1; seen = 0;
    while (lat < LIM && !seen) begin
      if (done_b) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("wiki_seen", 32'(seen), 1);
    @(negedge clk);
    chk("wiki_nwr", 32'(wcnt_b), 6);
    chk("wiki_order", 32'(oerr_b), 0);
    chk("wiki_ndone", 32'(dcnt_b), 1);
    chk("wiki_pt0", 32'(pt_b[0]), 5);
    model({96'd0, 32'h57696B69}, 4, 5);
    for (int n = 1; n <= 5; n++)
      chk($sformatf("wiki_pt%0d", n), 32'(pt_b[n]),
          32'(ct_b[n] ^ ks[n-1][7:0]));
`ifndef ARC4_DROP_EN
    for (int n = 0; n < 5; n++)
      chk($sformatf("wiki_lit%0d", n), 32'(pt_b[n+1]),
          32'(PT_WIK[n]));
`endif

    // Zero-length message, en held high throughout
    ct_a[0] = 8'd0;
    run_a(24'h123456, 0, 1'b1, "zero");
    chk("zero_pt0", 32'(pt_a[0]), 0);

    // Reset in the middle of KSA
    load_key_ct();
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    key_a = 24'h4B6579;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    repeat (599) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_rdy", 32'(rdy_a), 1);
    chk("mrst_wren", 32'(wren_a), 0);
    repeat (3) @(negedge clk);
    chk("mrst_nwr", 32'(wcnt_a), 0);
    chk("mrst_idle", 32'(rdy_a), 1);
    run_a(24'h4B6579, 9, 1'b0, "rerun");
    lit_key("rerun");

    // Back-to-back with en held high; key disturbed mid-run
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    key_a = 24'h4B6579;
    en_a = 1'b1;
    @(negedge clk);
    key_a = 24'($urandom);
    wait_done_a(lat, seen);
    chk("b2b1_seen", 32'(seen), 1);
    key_a = 24'h4B6579;
    @(negedge clk);
    check_a("b2b1", 24'h4B6579, 9);
    lit_key("b2b1");
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("b2b_restart", 32'(rdy_a), 0);
    en_a = 1'b0;
    wait_done_a(lat, seen);
    chk("b2b2_seen", 32'(seen), 1);
    @(negedge clk);
    check_a("b2b2", 24'h4B6579, 9);
    lit_key("b2b2");

    // Random keys / messages, including the longest message
    for (int r = 0; r < 3; r++) begin
      rk = 24'($urandom);
      len = (r == 0) ? 255 : int'($urandom_range(1, 40));
      ct_a[0] = 8'(len);
      for (int n = 1; n <= len; n++) ct_a[n] = 8'($urandom);
      run_a(rk, len, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
